// File: rtl/main_bus_arbiter.sv
// main_bus_arbiter: round-robin MainBus arbiter with a fixed snoop window, a Shared response latch and a hold timeout.
module main_bus_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int SNOOP_CYCLES = 2,
  parameter int MAX_HOLD     = 16
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_REQ-1:0]                      req_i,
  input  logic [NUM_REQ-1:0]                      done_i,
  input  logic [NUM_REQ-1:0]                      shared_i,
  output logic [NUM_REQ-1:0]                      gnt_o,
  output logic [(NUM_REQ>1?$clog2(NUM_REQ):1)-1:0] owner_id_o,
  output logic                                    snoop_valid_o,
  output logic                                    shared_o,
  output logic                                    bus_busy_o,
  output logic                                    timeout_o
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [2:0] {IDLE, GRANT, SNOOP, DATA, RELEASE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, owner_q, owner_d, pick;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [7:0] cnt_q, cnt_d;
  logic acc_q, acc_d, shared_q, shared_d, snoop_q, snoop_d;
  logic busy_q, busy_d, timeout_q, timeout_d, found;
  // Walk downward so the lowest offset from ptr (first match with wrap) wins.
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[(int'(ptr_q) + i) % NUM_REQ]) begin
        pick = IW'((int'(ptr_q) + i) % NUM_REQ);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    gnt_d = gnt_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    shared_d = shared_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        state_d = GRANT;
        owner_d = pick;
        gnt_d = NUM_REQ'(1) << pick;
      end
      GRANT: begin
        state_d = SNOOP;
        acc_d = 1'b0;
        cnt_d = '0;
      end
      SNOOP: begin
        acc_d = acc_q | (|(shared_i & ~gnt_q));
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(SNOOP_CYCLES - 1)) begin
          state_d = DATA;
          shared_d = acc_d;
          cnt_d = '0;
        end
      end
      DATA: begin
        cnt_d = cnt_q + 8'd1;
        if (|(done_i & gnt_q)) state_d = RELEASE;
        else if (cnt_q == 8'(MAX_HOLD - 1)) begin
          state_d = RELEASE;
          timeout_d = 1'b1;
        end
        if (state_d == RELEASE) begin
          gnt_d = '0;
          shared_d = 1'b0;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        ptr_d = owner_q == IW'(NUM_REQ - 1) ? '0 : owner_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    snoop_d = state_d == SNOOP;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      owner_q <= '0;
      gnt_q <= '0;
      cnt_q <= '0;
      acc_q <= 1'b0;
      shared_q <= 1'b0;
      snoop_q <= 1'b0;
      busy_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      gnt_q <= gnt_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      shared_q <= shared_d;
      snoop_q <= snoop_d;
      busy_q <= busy_d;
      timeout_q <= timeout_d;
    end
  end
  assign gnt_o = gnt_q;
  assign owner_id_o = owner_q;
  assign snoop_valid_o = snoop_q;
  assign shared_o = shared_q;
  assign bus_busy_o = busy_q;
  assign timeout_o = timeout_q;
endmodule

// File: tb/tb_main_bus_arbiter.sv
// tb_main_bus_arbiter: directed bench for main_bus_arbiter (NUM_REQ=4, S=2, MAX_HOLD=16) with a grant-order scoreboard.
module tb_main_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req_i = '0, done_i = '0, shared_i = '0;
  logic [3:0] gnt_o;
  logic [1:0] owner_id_o;
  logic snoop_valid_o, shared_o, bus_busy_o, timeout_o;
  int passed = 0, total = 0;
  int sb[$];
  int gap, busy, snoops, dcyc, tos, rel_to, rel_sh;
  logic sh;
  main_bus_arbiter #(.NUM_REQ(4), .SNOOP_CYCLES(2), .MAX_HOLD(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .done_i(done_i), .shared_i(shared_i),
    .gnt_o(gnt_o), .owner_id_o(owner_id_o), .snoop_valid_o(snoop_valid_o),
    .shared_o(shared_o), .bus_busy_o(bus_busy_o), .timeout_o(timeout_o)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  // Waits for a grant, then pops the expected owner from the scoreboard.
  task automatic wait_grant(input string tag, output int waited);
    int exp;
    waited = 0;
    while (gnt_o == 0 && waited < 20) begin
      step();
      waited++;
    end
    exp = sb.size() > 0 ? sb.pop_front() : -1;
    chk({tag, "_gnt"}, int'(gnt_o), exp < 0 ? -1 : (1 << exp));
    chk({tag, "_owner"}, int'(owner_id_o), exp);
  endtask
  // Drives one transaction from the GRANT cycle until the bus is idle again.
  task automatic run_txn(input int own, input int done_cycle, input logic [3:0] s1, input logic [3:0] s2,
                         input logic [3:0] snoop_done, input logic [3:0] data_noise,
                         output int nbusy, output int nsnoop, output int ndata, output logic sh1,
                         output int nto, output int rto, output int rsh);
    nbusy = 0; nsnoop = 0; ndata = 0; sh1 = 1'bx; nto = 0; rto = -1; rsh = -1;
    for (int c = 0; c < 40; c++) begin
      if (!bus_busy_o) break;
      nbusy++;
      nto += int'(timeout_o);
      done_i = '0;
      shared_i = '0;
      if (snoop_valid_o) begin
        nsnoop++;
        shared_i = nsnoop == 1 ? s1 : s2;
        done_i = snoop_done;
      end else if (gnt_o != 0 && nbusy > 1) begin
        ndata++;
        if (ndata == 1) sh1 = shared_o;
        done_i = ndata == done_cycle ? 4'(1 << own) : data_noise;
      end else if (gnt_o == 0) begin
        rto = int'(timeout_o);
        rsh = int'(shared_o);
      end
      step();
    end
    done_i = '0;
    shared_i = '0;
  endtask
  initial begin
    #3;
    chk("rst_gnt", int'(gnt_o), 0);
    chk("rst_owner", int'(owner_id_o), 0);
    chk("rst_snoop", int'(snoop_valid_o), 0);
    chk("rst_shared", int'(shared_o), 0);
    chk("rst_busy", int'(bus_busy_o), 0);
    chk("rst_timeout", int'(timeout_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    req_i = 4'b1111;
    sb.push_back(0); sb.push_back(1); sb.push_back(2); sb.push_back(3); sb.push_back(0);
    for (int t = 0; t < 5; t++) begin
      wait_grant("rr", gap);
      chk("rr_gap", gap, 1);
      run_txn(int'(owner_id_o), 1, '0, '0, '0, '0, busy, snoops, dcyc, sh, tos, rel_to, rel_sh);
      chk("rr_busy", busy, 5);
    end
    req_i = '0;
    step();
    req_i = 4'b0100;
    sb.push_back(2);
    wait_grant("single", gap);
    chk("single_lat", gap, 1);
    req_i = '0;
    run_txn(2, 2, '0, '0, '0, '0, busy, snoops, dcyc, sh, tos, rel_to, rel_sh);
    chk("single_busy", busy, 6);
    chk("single_snoop", snoops, 2);
    chk("single_shared", int'(sh), 0);
    chk("single_rel_shared", rel_sh, 0);
    req_i = 4'b0010;
    sb.push_back(1);
    wait_grant("sh1", gap);
    req_i = '0;
    run_txn(1, 1, 4'b0010, 4'b1010, '0, '0, busy, snoops, dcyc, sh, tos, rel_to, rel_sh);
    chk("sh1_shared", int'(sh), 1);
    chk("sh1_rel_shared", rel_sh, 0);
    req_i = 4'b0010;
    sb.push_back(1);
    wait_grant("sh2", gap);
    req_i = '0;
    run_txn(1, 1, 4'b0010, 4'b0010, '0, '0, busy, snoops, dcyc, sh, tos, rel_to, rel_sh);
    chk("sh2_shared", int'(sh), 0);
    req_i = 4'b0010;
    sb.push_back(1);
    wait_grant("to", gap);
    req_i = '0;
    run_txn(1, 0, '0, '0, '0, '0, busy, snoops, dcyc, sh, tos, rel_to, rel_sh);
    chk("to_data_cycles", dcyc, 16);
    chk("to_pulse_count", tos, 1);
    chk("to_at_release", rel_to, 1);
    req_i = 4'b0110;
    sb.push_back(2);
    wait_grant("to_ptr", gap);
    req_i = '0;
    run_txn(2, 16, '0, '0, '0, '0, busy, snoops, dcyc, sh, tos, rel_to, rel_sh);
    chk("done_wins_cycles", dcyc, 16);
    chk("done_wins_timeout", tos, 0);
    req_i = 4'b0100;
    sb.push_back(2);
    wait_grant("ign", gap);
    req_i = '0;
    run_txn(2, 3, '0, '0, 4'b0100, 4'b0001, busy, snoops, dcyc, sh, tos, rel_to, rel_sh);
    chk("ign_data_cycles", dcyc, 3);
    chk("ign_busy", busy, 7);
    req_i = 4'b1000;
    sb.push_back(3);
    wait_grant("rst_mid", gap);
    req_i = '0;
    step();
    chk("rst_mid_in_snoop", int'(snoop_valid_o), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_gnt", int'(gnt_o), 0);
    chk("rst_mid_snoop", int'(snoop_valid_o), 0);
    chk("rst_mid_busy", int'(bus_busy_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    req_i = 4'b0110;
    chk("post_rst_idle", int'(bus_busy_o), 0);
    sb.push_back(1);
    wait_grant("post_rst", gap);
    chk("post_rst_lat", gap, 1);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
